// File: rtl/control_unit_if.sv
// Control bundle between the hardwired sequencer and DataPath: instruction
// and halt request in, per-cycle datapath strobes out.
interface control_unit_if;
    logic        stop;
    logic [31:0] ir;
    logic [15:0] R_out;
    logic [15:0] R_in;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
    logic        Yin, Zin, Zhighout, Zlowout, HIin, LOin;
    logic        Cout;
    logic [31:0] cout_value;
    logic [4:0]  opcode;
    logic        run;
    logic        illegal;

    modport master (
        input  stop, ir,
        output R_out, R_in, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
               Yin, Zin, Zhighout, Zlowout, HIin, LOin, Cout, cout_value,
               opcode, run, illegal
    );

    modport slave (
        output stop, ir,
        input  R_out, R_in, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
               Yin, Zin, Zhighout, Zlowout, HIin, LOin, Cout, cout_value,
               opcode, run, illegal
    );
endinterface

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch in T0-T2, opcode-class execute in T3-T6,
// Moore strobes decoded from the state register and the registered IR.
module control_unit (
    input  logic           clock,
    input  logic           clear,
    control_unit_if.master bus,
    output logic [3:0]     o_dbg_state
);
    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        C_RR, C_IMM, C_UN, C_MD, C_NOP, C_HALT, C_ILL
    } class_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_illegal;
    class_t      w_class;
    logic [4:0]  w_op;
    logic [4:0]  w_alu_op;
    logic [15:0] w_ra_hot, w_rb_hot, w_rc_hot;

    assign w_op     = bus.ir[31:27];
    assign w_ra_hot = 16'h0001 << bus.ir[26:23];
    assign w_rb_hot = 16'h0001 << bus.ir[22:19];
    assign w_rc_hot = 16'h0001 << bus.ir[18:15];

    // Immediate forms reuse the reg-reg ALU encodings (add/and/or).
    always_comb begin
        w_class  = C_ILL;
        w_alu_op = w_op;
        case (w_op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: w_class = C_RR;
            5'b01100: begin w_class = C_IMM; w_alu_op = 5'b00011; end
            5'b01101: begin w_class = C_IMM; w_alu_op = 5'b00101; end
            5'b01110: begin w_class = C_IMM; w_alu_op = 5'b00110; end
            5'b10001, 5'b10010: w_class = C_UN;
            5'b10000, 5'b01111: w_class = C_MD;
            5'b11010: w_class = C_NOP;
            5'b11011: w_class = C_HALT;
            default:  w_class = C_ILL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state   <= S_RST;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_T3 && w_class == C_ILL)
                r_illegal <= 1'b1;
        end
    end

    // The opcode is only trustworthy from T3 on, so T3 is where the class
    // branch happens; nop/halt/illegal leave T3 without asserting strobes.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:  w_next = S_T0;
            S_T0:   w_next = bus.stop ? S_HALT : S_T1;
            S_T1:   w_next = S_T2;
            S_T2:   w_next = S_T3;
            S_T3: begin
                case (w_class)
                    C_NOP:          w_next = S_T0;
                    C_HALT, C_ILL:  w_next = S_HALT;
                    default:        w_next = S_T4;
                endcase
            end
            S_T4:   w_next = S_T5;
            S_T5:   w_next = (w_class == C_MD) ? S_T6 : S_T0;
            S_T6:   w_next = S_T0;
            S_HALT: w_next = S_HALT;
            default: w_next = S_RST;
        endcase
    end

    always_comb begin
        bus.R_out    = 16'h0000;
        bus.R_in     = 16'h0000;
        bus.PCout    = 1'b0;
        bus.PCin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.MARin    = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.Read     = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.Zhighout = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.Cout     = 1'b0;
        bus.opcode   = 5'b00000;
        case (r_state)
            S_T0: begin
                if (!bus.stop) begin
                    bus.PCout = 1'b1;
                    bus.MARin = 1'b1;
                    bus.IncPC = 1'b1;
                    bus.Zin   = 1'b1;
                end
            end
            S_T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                case (w_class)
                    C_RR, C_IMM, C_UN: begin bus.R_out = w_rb_hot; bus.Yin = 1'b1; end
                    C_MD:              begin bus.R_out = w_ra_hot; bus.Yin = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                bus.Zin    = 1'b1;
                bus.opcode = w_alu_op;
                case (w_class)
                    C_RR:    bus.R_out = w_rc_hot;
                    C_IMM:   bus.Cout  = 1'b1;
                    C_MD:    bus.R_out = w_rb_hot;
                    default: ;
                endcase
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                if (w_class == C_MD) bus.LOin = 1'b1;
                else                 bus.R_in = w_ra_hot;
            end
            S_T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.cout_value = {{13{bus.ir[18]}}, bus.ir[18:0]};
    assign bus.run        = (r_state != S_RST) && (r_state != S_HALT);
    assign bus.illegal    = r_illegal;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks fetch/execute sequences for each
// opcode class and checks every strobe against hand-computed values.
module tb_control_unit;
    logic       clock;
    logic       clear;
    logic [3:0] dbg_state;
    int         n_tests;
    int         n_fail;

    control_unit_if cu_if ();

    control_unit dut (
        .clock       (clock),
        .clear       (clear),
        .bus         (cu_if),
        .o_dbg_state (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Strobe vector bit positions
    localparam logic [14:0] PCOUT  = 15'h4000, PCIN   = 15'h2000, INCPC = 15'h1000;
    localparam logic [14:0] MARIN  = 15'h0800, MDRIN  = 15'h0400, MDROUT = 15'h0200;
    localparam logic [14:0] READ   = 15'h0100, IRIN   = 15'h0080, YIN   = 15'h0040;
    localparam logic [14:0] ZIN    = 15'h0020, ZHIOUT = 15'h0010, ZLOOUT = 15'h0008;
    localparam logic [14:0] HIIN   = 15'h0004, LOIN   = 15'h0002, COUT  = 15'h0001;
    localparam logic [14:0] NONE   = 15'h0000;

    function automatic logic [14:0] strobes();
        return {cu_if.PCout, cu_if.PCin, cu_if.IncPC, cu_if.MARin, cu_if.MDRin,
                cu_if.MDRout, cu_if.Read, cu_if.IRin, cu_if.Yin, cu_if.Zin,
                cu_if.Zhighout, cu_if.Zlowout, cu_if.HIin, cu_if.LOin, cu_if.Cout};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Check one cycle's Moore outputs, then advance to the next state.
    task automatic cyc(input string tag, input logic [14:0] s, input logic [15:0] ro,
                       input logic [15:0] ri, input logic [4:0] op, input logic run);
        check({tag, "_strb"},  {17'd0, strobes()}, {17'd0, s});
        check({tag, "_rout"},  {16'd0, cu_if.R_out}, {16'd0, ro});
        check({tag, "_rin"},   {16'd0, cu_if.R_in},  {16'd0, ri});
        check({tag, "_op"},    {27'd0, cu_if.opcode}, {27'd0, op});
        check({tag, "_run"},   {31'd0, cu_if.run}, {31'd0, run});
        step();
    endtask

    task automatic fetch(input string tag);
        check({tag, "_st_t0"}, {28'd0, dbg_state}, 32'd1);
        cyc({tag, "_t0"}, PCOUT | MARIN | INCPC | ZIN, 16'h0, 16'h0, 5'd0, 1'b1);
        cyc({tag, "_t1"}, ZLOOUT | PCIN | READ | MDRIN, 16'h0, 16'h0, 5'd0, 1'b1);
        cyc({tag, "_t2"}, MDROUT | IRIN, 16'h0, 16'h0, 5'd0, 1'b1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_rst_state", {28'd0, dbg_state}, 32'd0);
        check("clr_illegal", {31'd0, cu_if.illegal}, 32'd0);
        cyc("clr_rst", NONE, 16'h0, 16'h0, 5'd0, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear   = 1'b1;
        cu_if.stop = 1'b0;
        cu_if.ir   = 32'h0;

        step();
        step();
        clear = 1'b0;
        check("rst_state", {28'd0, dbg_state}, 32'd0);
        check("rst_illegal", {31'd0, cu_if.illegal}, 32'd0);
        cyc("rst", NONE, 16'h0, 16'h0, 5'd0, 1'b0);

        // add R1,R2,R3
        cu_if.ir = 32'h18918000;
        fetch("add");
        cyc("add_t3", YIN, 16'h0004, 16'h0, 5'd0, 1'b1);
        cyc("add_t4", ZIN, 16'h0008, 16'h0, 5'b00011, 1'b1);
        cyc("add_t5", ZLOOUT, 16'h0, 16'h0002, 5'd0, 1'b1);

        // neg R5,R0
        cu_if.ir = 32'h8A800000;
        fetch("neg");
        cyc("neg_t3", YIN, 16'h0001, 16'h0, 5'd0, 1'b1);
        cyc("neg_t4", ZIN, 16'h0000, 16'h0, 5'b10001, 1'b1);
        cyc("neg_t5", ZLOOUT, 16'h0, 16'h0020, 5'd0, 1'b1);

        // addi R2,R4,-5
        cu_if.ir = 32'h6127FFFB;
        fetch("addi");
        cyc("addi_t3", YIN, 16'h0010, 16'h0, 5'd0, 1'b1);
        check("addi_cval", cu_if.cout_value, 32'hFFFFFFFB);
        cyc("addi_t4", ZIN | COUT, 16'h0, 16'h0, 5'b00011, 1'b1);
        cyc("addi_t5", ZLOOUT, 16'h0, 16'h0004, 5'd0, 1'b1);

        // mul R6,R7
        cu_if.ir = 32'h83380000;
        fetch("mul");
        cyc("mul_t3", YIN, 16'h0040, 16'h0, 5'd0, 1'b1);
        cyc("mul_t4", ZIN, 16'h0080, 16'h0, 5'b10000, 1'b1);
        cyc("mul_t5", ZLOOUT | LOIN, 16'h0, 16'h0, 5'd0, 1'b1);
        cyc("mul_t6", ZHIOUT | HIIN, 16'h0, 16'h0, 5'd0, 1'b1);

        // nop, with stop raised during T3 so it lands on the following T0
        cu_if.ir = 32'hD0000000;
        fetch("nop");
        cu_if.stop = 1'b1;
        cyc("nop_t3", NONE, 16'h0, 16'h0, 5'd0, 1'b1);
        check("stop_st_t0", {28'd0, dbg_state}, 32'd1);
        cyc("stop_t0", NONE, 16'h0, 16'h0, 5'd0, 1'b1);
        cu_if.stop = 1'b0;
        check("stop_st_halt", {28'd0, dbg_state}, 32'd8);
        cyc("stop_halt", NONE, 16'h0, 16'h0, 5'd0, 1'b0);
        check("stop_hold", {28'd0, dbg_state}, 32'd8);
        do_clear();

        // halt
        cu_if.ir = 32'hD8000000;
        fetch("hlt");
        cyc("hlt_t3", NONE, 16'h0, 16'h0, 5'd0, 1'b1);
        check("hlt_st", {28'd0, dbg_state}, 32'd8);
        check("hlt_illegal", {31'd0, cu_if.illegal}, 32'd0);
        cyc("hlt_halt", NONE, 16'h0, 16'h0, 5'd0, 1'b0);
        do_clear();

        // undefined opcode 11111
        cu_if.ir = 32'hF8000000;
        fetch("ill");
        check("ill_t3_flag", {31'd0, cu_if.illegal}, 32'd0);
        cyc("ill_t3", NONE, 16'h0, 16'h0, 5'd0, 1'b1);
        check("ill_st", {28'd0, dbg_state}, 32'd8);
        check("ill_flag", {31'd0, cu_if.illegal}, 32'd1);
        cyc("ill_halt", NONE, 16'h0, 16'h0, 5'd0, 1'b0);
        check("ill_sticky", {31'd0, cu_if.illegal}, 32'd1);
        do_clear();

        // clear in the middle of an add (during T4)
        cu_if.ir = 32'h18918000;
        fetch("mid");
        cyc("mid_t3", YIN, 16'h0004, 16'h0, 5'd0, 1'b1);
        check("mid_st_t4", {28'd0, dbg_state}, 32'd5);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("mid_st_rst", {28'd0, dbg_state}, 32'd0);
        cyc("mid_rst", NONE, 16'h0, 16'h0, 5'd0, 1'b0);
        check("mid_st_t0", {28'd0, dbg_state}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the CPU. It generates the per-cycle datapath control strobes that the phase-1 benches drive by hand today: fetch in T0–T2, then an opcode-dependent execute sequence. It sits beside `DataPath`, reads the instruction register, and drives every `*in`/`*out` strobe, `Read`, `IncPC` and the ALU `opcode`. It is one-hot per step and advances one state per `clock`.

## Interface
- No parameters.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `clear`  in  1  synchronous, active-high reset.
- `stop`  in  1  halt request, sampled only in state T0.
- `ir`  in  32  instruction register contents from `DataPath`.
  - `ir[31:27]` is the opcode.
  - `ir[26:23]` is Ra, `ir[22:19]` is Rb, `ir[18:15]` is Rc.
  - `ir[18:0]` is the immediate C.
- `R_out`  out  16  one-hot register-out enables R0..R15.
- `R_in`  out  16  one-hot register-in enables R0..R15.
- `PCout`, `PCin`, `IncPC`, `MARin`, `MDRin`, `MDRout`, `Read`, `IRin`  out  1 each  datapath strobes.
- `Yin`, `Zin`, `Zhighout`, `Zlowout`, `HIin`, `LOin`  out  1 each  datapath strobes.
- `Cout`  out  1  drive `cout_value` onto the bus.
- `cout_value`  out  32  sign-extended C, `{{13{ir[18]}}, ir[18:0]}`.
- `opcode`  out  5  ALU operation; 0 when no ALU op is active.
- `run`  out  1  1 while executing; 0 in RST and HALT.
- `illegal`  out  1  sticky; set when an undefined opcode is decoded.

## Operation
- States: RST, T0, T1, T2, T3, T4, T5, T6, HALT.
- Outputs are Moore: a combinational decode of the state register and `ir`.
- Any strobe not listed for a state is 0.
- Fetch:
  - T0: `PCout`, `MARin`, `IncPC`, `Zin`.
  - T1: `Zlowout`, `PCin`, `Read`, `MDRin`.
  - T2: `MDRout`, `IRin`.
- Opcode classes and execute sequences:
  - **Reg-reg** (add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011):
    - T3: `R_out[Rb]`, `Yin`.
    - T4: `R_out[Rc]`, `opcode=ir[31:27]`, `Zin`.
    - T5: `Zlowout`, `R_in[Ra]`; then T0.
  - **Immediate** (addi 01100, andi 01101, ori 01110): as reg-reg, except T4 drives `Cout` instead of `R_out[Rc]`, and `opcode` is mapped to add/and/or respectively.
  - **Unary** (neg 10001, not 10010):
    - T3: `R_out[Rb]`, `Yin`.
    - T4: `opcode`, `Zin`.
    - T5: `Zlowout`, `R_in[Ra]`; then T0.
  - **Mul/div** (mul 10000, div 01111):
    - T3: `R_out[Ra]`, `Yin`.
    - T4: `R_out[Rb]`, `opcode`, `Zin`.
    - T5: `Zlowout`, `LOin`.
    - T6: `Zhighout`, `HIin`; then T0.
  - **nop** (11010): T2 → T0.
  - **halt** (11011): T2 → HALT.
  - **Any other opcode**: T2 → HALT and set `illegal`.
- Opcode decode in T2 uses the value being loaded. Because the IR updates at the end of T2, the T2 → T3 transition decodes `ir` in T3. Concretely: the branch out of T2 goes to a common T3, and T3 redirects nop, halt and illegal opcodes before asserting any strobes.
  - Implementation rule: the decision is taken in T3 from the registered `ir`.
  - For nop, halt and illegal opcodes, T3 asserts no strobes and transitions to T0, HALT and HALT respectively.
- `stop`: if `stop=1` while in T0, the T0 strobes are suppressed and the next state is HALT.
- HALT: all strobes 0, `run=0`, `opcode=0`. It is held until `clear`.
- `clear`: on the next rising edge, state ← RST and `illegal` ← 0. This takes priority over every transition, including mid-instruction. RST has all outputs 0 and goes to T0 on the following edge if `clear=0`.

## Timing
- All outputs are valid combinationally within the cycle of their state. The datapath captures on the closing rising edge.
- Reset values (RST): every strobe 0, `R_out=R_in=0`, `opcode=0`, `run=0`, `illegal=0`.
- Cycles per instruction, counted from T0:
  - reg-reg, immediate, unary: 6.
  - mul/div: 7.
  - nop: 4.
  - halt/illegal: 4, then HALT.
- Exactly one `R_out` bit and one `R_in` bit may be high at a time; both are never high in the same cycle.
- Ra equal to Rb is legal; there is no special case for R0.
- `stop` asserted in any state other than T0 takes effect at the next T0.

## Test plan
- **Reset:** hold `clear` 2 cycles then release → RST for 1 cycle, then T0 with `PCout=MARin=IncPC=Zin=1` and `run=1`.
- **add:** `ir=0x18918000` (add R1,R2,R3) → T3 `R_out=0x0004`, `Yin`; T4 `R_out=0x0008`, `opcode=00011`, `Zin`; T5 `R_in=0x0002`, `Zlowout`; T0 six cycles after the previous T0.
- **neg:** `ir=0x8A800000` (neg R5,R0) → T3 `R_out=0x0001`; T4 `opcode=10001`, `R_out=0`; T5 `R_in=0x0020`.
- **addi:** `ir=0x6127FFFB` (addi R2,R4,-5) → T4 `Cout=1`, `cout_value=0xFFFFFFFB`, `opcode=00011`; T5 `R_in=0x0004`.
- **mul:** `ir=0x83380000` (mul R6,R7) → T5 `LOin`+`Zlowout`; T6 `HIin`+`Zhighout`; 7-cycle instruction.
- **Halt, illegal, stop and clear:**
  - `ir=0xD8000000` → HALT, `run=0`, `illegal=0`.
  - `ir=0xF8000000` → HALT, `illegal=1`.
  - `stop=1` in T0 → HALT with no T0 strobes.
  - `clear` asserted in T4 → RST next edge, `illegal` cleared.
